// File: rtl/ame_pkg.sv
// ame_pkg: shared AME types and geometry
// for the Sobel sequencer and datapath.
package ame_pkg;

  localparam int SOBEL_TAPS = 6;
  localparam int SOBEL_OUT  = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_H,
    RD_V,
    WAIT,
    OUT
  } sobel_ctl_t;

  typedef enum logic {
    PASS_H,
    PASS_V
  } pass_t;

endpackage

// File: rtl/ame_sobel_ctrl.sv
// ame_sobel_ctrl: runs gx then gy passes through
// the shared Sobel datapath, captures both results.
import ame_pkg::*;

module ame_sobel_ctrl #(
  parameter int LINE_DATA_BITS = 7,
  parameter int COMP_DATA_BITS = 8,
  parameter int ADDR_BITS      = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [ADDR_BITS-1:0] req_base_i,
  output logic                 rd_en_o,
  output logic                 rd_sel_o,
  output logic [ADDR_BITS-1:0] rd_addr_o,
  input  logic [SOBEL_TAPS*LINE_DATA_BITS-1:0] rd_data_i,
  output logic                 comp_init_o,
  output logic [SOBEL_TAPS*LINE_DATA_BITS-1:0] line_data_o,
  input  logic                 comp_done_i,
  input  logic [SOBEL_OUT*SOBEL_OUT*COMP_DATA_BITS-1:0] comp_data_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [SOBEL_OUT*SOBEL_OUT*COMP_DATA_BITS-1:0] gx_o,
  output logic [SOBEL_OUT*SOBEL_OUT*COMP_DATA_BITS-1:0] gy_o
);

  localparam int RW = SOBEL_OUT * SOBEL_OUT * COMP_DATA_BITS;
  localparam logic [2:0] K_LAST = 3'(SOBEL_TAPS - 1);

  sobel_ctl_t r_state;
  sobel_ctl_t w_state_nxt;
  logic [2:0] r_k;
  logic [ADDR_BITS-1:0] r_base;
  pass_t r_pass;
  logic r_rd_dly;
  logic [RW-1:0] r_gx;
  logic [RW-1:0] r_gy;
  logic w_rd;
  logic w_last;
  logic w_cap;

  assign w_rd   = (r_state == RD_H) || (r_state == RD_V);
  assign w_last = w_rd && (r_k == K_LAST);
  // gy can only finish once both passes were issued
  assign w_cap  = comp_done_i &&
                  ((r_state == RD_V) || (r_state == WAIT));

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (req_valid_i) w_state_nxt = RD_H;
      RD_H: if (w_last) w_state_nxt = RD_V;
      RD_V: if (w_last) w_state_nxt = WAIT;
      WAIT: if (w_cap && r_pass == PASS_V)
              w_state_nxt = OUT;
      OUT:  if (res_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready_o = 1'b0;
    rd_en_o     = 1'b0;
    rd_sel_o    = 1'b0;
    rd_addr_o   = '0;
    comp_init_o = 1'b0;
    res_valid_o = 1'b0;
    unique case (r_state)
      IDLE: req_ready_o = 1'b1;
      RD_H, RD_V: begin
        rd_en_o     = 1'b1;
        rd_sel_o    = (r_state == RD_V);
        rd_addr_o   = r_base + ADDR_BITS'(r_k);
        comp_init_o = (r_k == 3'd0);
      end
      OUT: res_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Window base latch and per-pass step counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_base <= '0;
      r_k    <= '0;
    end else begin
      if (r_state == IDLE && req_valid_i)
        r_base <= req_base_i;
      if (w_last || !w_rd) r_k <= '0;
      else                 r_k <= r_k + 3'd1;
    end
  end

  // Read data lands one cycle after the strobe
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_rd_dly <= 1'b0;
    else          r_rd_dly <= w_rd;
  end

  assign line_data_o = r_rd_dly ? rd_data_i : '0;

  // Route datapath results: first gx, then gy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pass <= PASS_H;
      r_gx   <= '0;
      r_gy   <= '0;
    end else if (w_cap) begin
      if (r_pass == PASS_H) begin
        r_gx   <= comp_data_i;
        r_pass <= PASS_V;
      end else begin
        r_gy   <= comp_data_i;
        r_pass <= PASS_H;
      end
    end
  end

  assign gx_o = r_gx;
  assign gy_o = r_gy;

endmodule

// File: tb/tb_ame_sobel_ctrl.sv
// tb_ame_sobel_ctrl: scoreboard bench with line memory
// and Sobel datapath models around the sequencer.
module tb_ame_sobel_ctrl;
  import ame_pkg::*;

  localparam int LB = 7;
  localparam int CB = 8;
  localparam int AB = 6;
  localparam int LW = 6 * LB;
  localparam int RW = 16 * CB;
  localparam logic [RW-1:0] R0  = '0;
  localparam logic [RW-1:0] R8  = {16{8'h08}};
  localparam logic [RW-1:0] R16 = {16{8'h10}};

  typedef struct {
    int cyc;
    logic sel;
    logic [AB-1:0] addr;
  } rd_t;

  typedef struct {
    logic [RW-1:0] gx;
    logic [RW-1:0] gy;
  } res_t;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b1;
  logic req_valid_i = 1'b0;
  logic req_ready_o;
  logic [AB-1:0] req_base_i = '0;
  logic rd_en_o;
  logic rd_sel_o;
  logic [AB-1:0] rd_addr_o;
  logic [LW-1:0] rd_data_i;
  logic comp_init_o;
  logic [LW-1:0] line_data_o;
  logic comp_done_i;
  logic [RW-1:0] comp_data_i;
  logic res_valid_o;
  logic res_ready_i = 1'b1;
  logic [RW-1:0] gx_o;
  logic [RW-1:0] gy_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int mode = 0;
  int n_init = 0;

  rd_t  rd_q[$];
  res_t res_q[$];
  int   init_q[$];
  int   rise_q[$];
  int   acc_t[$];

  ame_sobel_ctrl #(
    .LINE_DATA_BITS(LB),
    .COMP_DATA_BITS(CB),
    .ADDR_BITS(AB)
  ) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_base_i(req_base_i),
    .rd_en_o(rd_en_o),
    .rd_sel_o(rd_sel_o),
    .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i),
    .comp_init_o(comp_init_o),
    .line_data_o(line_data_o),
    .comp_done_i(comp_done_i),
    .comp_data_i(comp_data_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .gx_o(gx_o),
    .gy_o(gy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [RW-1:0] act,
                     input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // image: 0 flat 5, 1 ramp both, 2 ramp v / 2x ramp h
  function automatic logic [LB-1:0] pix(input logic s,
                                        input logic [AB-1:0] a);
    case (mode)
      0: return LB'(5);
      1: return LB'(int'(a));
      default: return s ? LB'(2 * int'(a)) : LB'(int'(a));
    endcase
  endfunction

  // line memories: one-cycle read latency, junk otherwise
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     rd_data_i <= '0;
    else if (rd_en_o) rd_data_i <= {6{pix(rd_sel_o, rd_addr_o)}};
    else              rd_data_i <= '1;
  end

  // Sobel datapath model (row-difference kernel 1-2-1)
  logic [LW-1:0] rows [5];
  logic [2:0] dp_step;

  function automatic logic [RW-1:0] sobel(input logic [LW-1:0] l5);
    logic [LW-1:0] w [6];
    logic [RW-1:0] o;
    int s;
    for (int i = 0; i < 5; i++) w[i] = rows[i];
    w[5] = l5;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int j = 0; j < 3; j++)
          s += ((j == 1) ? 2 : 1) *
               (int'(w[r+2][(c+j)*LB +: LB]) -
                int'(w[r][(c+j)*LB +: LB]));
        o[(r*4+c)*CB +: CB] = CB'(s);
      end
    return o;
  endfunction

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dp_step     <= '0;
      comp_done_i <= 1'b0;
      comp_data_i <= '0;
    end else begin
      comp_done_i <= 1'b0;
      if (dp_step >= 3'd1 && dp_step <= 3'd5)
        rows[dp_step - 3'd1] <= line_data_o;
      if (dp_step == 3'd6) begin
        comp_done_i <= 1'b1;
        comp_data_i <= sobel(line_data_o);
      end
      if (comp_init_o)
        dp_step <= 3'd1;
      else if (dp_step == 3'd6 || dp_step == 3'd0)
        dp_step <= 3'd0;
      else
        dp_step <= dp_step + 3'd1;
    end
  end

  // monitor: timing, addresses, forwarding, results
  initial begin
    logic prv_en;
    logic prv_sel;
    logic [AB-1:0] prv_addr;
    logic prv_valid;
    logic want_idle;
    logic [RW-1:0] hold_gx;
    logic [RW-1:0] hold_gy;
    logic [LW-1:0] exp_line;
    rd_t  e;
    res_t r;
    int t;
    prv_en = 0; prv_sel = 0; prv_addr = '0;
    prv_valid = 0; want_idle = 0;
    hold_gx = '0; hold_gy = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        prv_en = 0; prv_valid = 0; want_idle = 0;
      end else begin
        if (rd_en_o) begin
          if (rd_q.size() == 0) begin
            chk("rd_unexpected", RW'(rd_en_o), RW'(0));
          end else begin
            e = rd_q.pop_front();
            chk("rd_cyc", RW'(cyc), RW'(e.cyc));
            chk("rd_sel", RW'(rd_sel_o), RW'(e.sel));
            chk("rd_addr", RW'(rd_addr_o), RW'(e.addr));
          end
        end
        if (comp_init_o) begin
          n_init++;
          if (init_q.size() == 0)
            chk("init_unexpected", RW'(comp_init_o), RW'(0));
          else
            chk("init_cyc", RW'(cyc), RW'(init_q.pop_front()));
        end
        exp_line = prv_en ? {6{pix(prv_sel, prv_addr)}} : '0;
        chk("line_data", RW'(line_data_o), RW'(exp_line));
        if (want_idle) begin
          chk("idle_ready", RW'(req_ready_o), RW'(1));
          chk("valid_drop", RW'(res_valid_o), RW'(0));
          want_idle = 0;
        end
        if (res_valid_o && !prv_valid) begin
          if (rise_q.size() == 0)
            chk("rise_unexpected", RW'(res_valid_o), RW'(0));
          else
            chk("valid_rise", RW'(cyc), RW'(rise_q.pop_front()));
          hold_gx = gx_o;
          hold_gy = gy_o;
        end
        if (res_valid_o && prv_valid) begin
          chk("hold_gx", gx_o, hold_gx);
          chk("hold_gy", gy_o, hold_gy);
        end
        if (res_valid_o)
          chk("out_ready", RW'(req_ready_o), RW'(0));
        if (res_valid_o && res_ready_i) begin
          if (res_q.size() == 0) begin
            chk("res_unexpected", RW'(res_valid_o), RW'(0));
          end else begin
            r = res_q.pop_front();
            chk("gx", gx_o, r.gx);
            chk("gy", gy_o, r.gy);
          end
          want_idle = 1;
        end
        if (req_valid_i && req_ready_o) begin
          t = cyc;
          acc_t.push_back(t);
          for (int k = 0; k < 12; k++) begin
            e.cyc  = t + 1 + k;
            e.sel  = (k >= 6);
            e.addr = AB'(int'(req_base_i) + (k % 6));
            rd_q.push_back(e);
          end
          init_q.push_back(t + 1);
          init_q.push_back(t + 7);
          rise_q.push_back(t + 15);
        end
        prv_en    = rd_en_o;
        prv_sel   = rd_sel_o;
        prv_addr  = rd_addr_o;
        prv_valid = res_valid_o;
      end
    end
  end

  task automatic issue(input logic [AB-1:0] base,
                       input logic [RW-1:0] egx,
                       input logic [RW-1:0] egy);
    int n0;
    int b;
    res_t r;
    n0 = acc_t.size();
    b = 0;
    r.gx = egx;
    r.gy = egy;
    res_q.push_back(r);
    req_base_i  = base;
    req_valid_i = 1'b1;
    while (acc_t.size() == n0 && b < 100) begin
      @(posedge clk_i); #1; b++;
    end
    chk("accept", RW'(acc_t.size()), RW'(n0 + 1));
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (res_q.size() != 0 && b < 200) begin
      @(posedge clk_i); #1; b++;
    end
    chk("drain", RW'(res_q.size()), RW'(0));
    res_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, RW'(req_ready_o), RW'(1));
    chk({tag, "_rd_en"}, RW'(rd_en_o), RW'(0));
    chk({tag, "_rd_sel"}, RW'(rd_sel_o), RW'(0));
    chk({tag, "_rd_addr"}, RW'(rd_addr_o), RW'(0));
    chk({tag, "_init"}, RW'(comp_init_o), RW'(0));
    chk({tag, "_line"}, RW'(line_data_o), RW'(0));
    chk({tag, "_valid"}, RW'(res_valid_o), RW'(0));
    chk({tag, "_gx"}, gx_o, R0);
    chk({tag, "_gy"}, gy_o, R0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int i0;
    int b;
    #1 rst_n_i = 1'b0;
    #2 chk_reset_outs("reset");
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    mode = 0;
    issue(6'd0, R0, R0);
    drain();

    mode = 1;
    issue(6'd0, R8, R8);
    drain();

    mode = 2;
    issue(6'd3, R8, R16);
    drain();

    mode = 1;
    res_ready_i = 1'b0;
    issue(6'd20, R8, R8);
    b = 0;
    while (!res_valid_o && b < 50) begin
      @(posedge clk_i); #1; b++;
    end
    chk("bp_valid", RW'(res_valid_o), RW'(1));
    repeat (10) @(posedge clk_i);
    #1 res_ready_i = 1'b1;
    drain();

    mode = 0;
    issue(6'd61, R0, R0);
    drain();

    mode = 1;
    issue(6'd0, R8, R8);
    repeat (8) @(posedge clk_i);
    #1 rst_n_i = 1'b0;
    #1 chk_reset_outs("midrst");
    res_q.delete();
    rd_q.delete();
    init_q.delete();
    rise_q.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    issue(6'd10, R8, R8);
    drain();

    mode = 1;
    n0 = acc_t.size();
    i0 = n_init;
    res_q.push_back('{R8, R8});
    res_q.push_back('{R8, R8});
    req_base_i  = 6'd0;
    req_valid_i = 1'b1;
    b = 0;
    while (acc_t.size() < n0 + 2 && b < 100) begin
      @(posedge clk_i); #1; b++;
      if (acc_t.size() > n0) req_base_i = 6'd30;
    end
    req_valid_i = 1'b0;
    chk("b2b_accepts", RW'(acc_t.size()), RW'(n0 + 2));
    if (acc_t.size() >= n0 + 2)
      chk("b2b_gap", RW'(acc_t[n0+1] - acc_t[n0]), RW'(16));
    drain();
    chk("b2b_inits", RW'(n_init - i0), RW'(4));

    chk("rd_q_left", RW'(rd_q.size()), RW'(0));
    chk("init_q_left", RW'(init_q.size()), RW'(0));
    chk("rise_q_left", RW'(rise_q.size()), RW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ame_sobel_ctrl.md
# ame_sobel_ctrl

Sequencer for the shared Sobel gradient datapath of the affine motion estimation (AME) engine. Per accepted 4x4 block request, the sequencer runs two back-to-back passes through the single Sobel datapath instance:

- horizontal filter (gx) on line data from the vertical line memory;
- vertical filter (gy) on line data from the horizontal line memory.

It generates the line-memory reads, aligns the read data to the datapath's 6-step schedule, captures both 4x4 result sets and presents them through a valid/ready output.

## Interface
Parameters:
- LINE_DATA_BITS, 7, pixel width of one line-memory lane
- COMP_DATA_BITS, 8, width of one gradient result (two's complement)
- ADDR_BITS, 6, line-memory address width

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  block request valid
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_base_i  in  ADDR_BITS  first line address of the 6-line window
- rd_en_o  out  1  line-memory read strobe
- rd_sel_o  out  1  0 = vertical memory (gx pass), 1 = horizontal memory (gy pass)
- rd_addr_o  out  ADDR_BITS  line address
- rd_data_i  in  6*LINE_DATA_BITS  6 pixels, valid exactly 1 cycle after rd_en_o
- comp_init_o  out  1  datapath start pulse
- line_data_o  out  6*LINE_DATA_BITS  pixels to datapath
- comp_done_i  in  1  datapath result pulse
- comp_data_i  in  16*COMP_DATA_BITS  datapath 4x4 result, valid in the comp_done_i cycle
- res_valid_o  out  1  gx/gy result valid
- res_ready_i  in  1  result consumer ready
- gx_o, gy_o  out  16*COMP_DATA_BITS each  captured results

## Operation
FSM states: IDLE, RD_H, RD_V, WAIT, OUT.

- **IDLE:** req_ready_o = 1. On req_valid_i, latch req_base_i and go to RD_H.
- **RD_H:** 6 cycles, step counter k = 0..5.
  - rd_en_o = 1, rd_sel_o = 0, rd_addr_o = base + k (mod 2^ADDR_BITS).
  - comp_init_o = 1 at k = 0 only.
  - Go to RD_V after k = 5.
- **RD_V:** identical to RD_H, with rd_sel_o = 1. Go to WAIT after k = 5.
- **WAIT:** wait for the second comp_done_i, then go to OUT.
- **OUT:** res_valid_o = 1; gx_o/gy_o held stable. On res_ready_i, go to IDLE.
- **Line-data forwarding:**
  - line_data_o = rd_data_i in every cycle following a rd_en_o cycle (registered rd_en delay flag).
  - line_data_o = 0 otherwise.
- **Result capture:**
  - A 1-bit pass counter routes each comp_done_i: the first pulse writes gx, the second writes gy, after which the counter clears.
  - comp_done_i outside RD_V/WAIT is ignored.
- No arithmetic is performed in this block; results pass through bit-exact.

## Timing
Request accepted at cycle T:
- T+1..T+6: gx reads. comp_init_o at T+1; the datapath consumes step n at T+1+n.
- T+7..T+12: gy reads. comp_init_o at T+7, which falls in the datapath's last step, so the datapath restarts with no idle gap.
- T+8: gx done, captured. T+14: gy done, captured.
- T+15: res_valid_o rises. Minimum request-to-result latency is 15 cycles.
- With res_ready_i held high, req_ready_o is high at T+16, giving a throughput of 1 block per 16 cycles.
- res_valid_o stays high, and data stays stable, until res_ready_i. No request is accepted while in OUT.

Reset values (asynchronous, valid mid-operation):
- FSM = IDLE, counters = 0, pass = 0.
- All outputs 0, except req_ready_o = 1 (combinational from IDLE).
- The datapath shares rst_n_i, so no stale comp_done_i can follow a reset.

Boundary conditions:
- Address wrap: base = 2^ADDR_BITS-3 reads wrap to 0..2.
- req_valid_i while busy is not accepted; it is held off by req_ready_o = 0.
- res_ready_i while res_valid_o is low has no effect.

## Structure
- Shared package ame_pkg holds:
  - sobel_ctl_t FSM enum;
  - pass enum PASS_H/PASS_V;
  - localparams SOBEL_TAPS = 6, SOBEL_OUT = 4.
- No sub-module is instantiated here. The Sobel datapath sits beside this block in the AME top, wired via comp_init/line_data/comp_done/comp_data.
- Expected size: roughly 200 RTL lines.

## Test plan
- **Single request, flat image:**
  - Stimulus: base = 0, all pixels = 5, res_ready_i = 1.
  - Required response: reads at T+1..T+12 with addr 0..5, sel 0 then 1; res_valid_o at T+15; all 32 results = 0.
- **Ramp image:**
  - Stimulus: line k holds all pixels = k, in both memories.
  - Required response: every gx and gy element = 8 (0x08).
- **Back-pressure:**
  - Stimulus: res_ready_i low for 10 cycles after res_valid_o.
  - Required response: gx_o/gy_o stable; req_ready_o = 0 throughout; IDLE one cycle after res_ready_i.
- **Address wrap:**
  - Stimulus: ADDR_BITS = 6, base = 61.
  - Required response: rd_addr_o sequence 61, 62, 63, 0, 1, 2, repeated for the gy pass.
- **Reset at T+9:**
  - Required response: all outputs 0 immediately.
  - Required response: a new request at base = 10 completes normally with the correct ramp results.
- **Back-to-back requests:**
  - Stimulus: req_valid_i held high.
  - Required response: second acceptance exactly 16 cycles after the first; comp_init_o pulses exactly 4 times.
